// File: rtl/simon_pkg.sv
// Shared types for the Sly-Man-Says round controller: FSM states and colours.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        LOSE     = 3'd5,
        WIN      = 3'd6
    } simon_state_t;

    typedef logic [1:0] color_t;

    localparam color_t RED    = 2'd0;
    localparam color_t GREEN  = 2'd1;
    localparam color_t BLUE   = 2'd2;
    localparam color_t YELLOW = 2'd3;

    // Larger of two integers, used to size the shared phase timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/simon_sequencer_phase_timer.sv
// Phase timer for playback: counts cycles from 0 and pulses done on the
// last cycle of a phase, wrapping to 0 so the next phase starts cleanly.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // The phase ends in the cycle where count reaches limit-1, so a phase lasts exactly limit cycles.
    assign done = !load && (count == (limit - 1'b1));

    // Clear on load or at phase end, otherwise count up.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (load || done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// Game-round controller: grows a random colour sequence one step per round,
// plays it on the LED driver, then checks the player's presses against it.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  random_num,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_color,
    output logic                         led_en,
    output logic [1:0]                   led_color,
    output logic                         input_ready,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         game_over,
    output logic                         win
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);

    localparam logic [TW-1:0] ON_LIMIT  = TW'(ON_CYCLES);
    localparam logic [TW-1:0] OFF_LIMIT = TW'(OFF_CYCLES);
    localparam logic [LW-1:0] FULL_LEN  = LW'(MAX_LEN);

    simon_state_t    state;
    logic [LW-1:0]   len;
    logic [LW-1:0]   idx;
    logic [LW-1:0]   last_idx;
    logic            timer_load;
    logic [TW-1:0]   timer_limit;
    logic            timer_done;
    color_t          new_color;
    color_t          cur_color;
    logic            unused_random;

    // Sized to the full index range so len/idx select it without truncation;
    // entries at or beyond len are never read.
    color_t seq [2**LW];

    assign new_color     = random_num[1:0];
    assign unused_random = ^random_num[31:2];
    assign last_idx      = len - 1'b1;
    assign cur_color     = seq[idx];

    // The timer only runs during playback; it is held at 0 elsewhere so
    // the first lit phase after ADD starts from a fresh count.
    assign timer_load  = (state != SHOW_ON) && (state != SHOW_OFF);
    assign timer_limit = (state == SHOW_ON) ? ON_LIMIT : OFF_LIMIT;

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .limit (timer_limit),
        .done  (timer_done)
    );

    // Append the sampled colour while in ADD.
    always_ff @(posedge clk) begin
        // NOTE: the sequence store has no reset; a new game overwrites it in order before any entry is read.
        if (state == ADD) begin
            seq[len] <= new_color;
        end
    end

    // Round control: grow, play back, and check the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE, LOSE, WIN: begin
                    if (start) begin
                        len   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    len   <= len + 1'b1;
                    idx   <= '0;
                    state <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer_done) begin
                        state <= SHOW_OFF;
                    end
                end
                SHOW_OFF: begin
                    if (timer_done) begin
                        if (idx == last_idx) begin
                            idx   <= '0;
                            state <= WAIT_IN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SHOW_ON;
                        end
                    end
                end
                WAIT_IN: begin
                    if (btn_valid) begin
                        if (btn_color != cur_color) begin
                            state <= LOSE;
                        end else if (idx != last_idx) begin
                            idx <= idx + 1'b1;
                        end else if (len == FULL_LEN) begin
                            state <= WIN;
                        end else begin
                            state <= ADD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so reset clears them at once
    // and no input reaches an output combinationally.
    assign led_en      = (state == SHOW_ON);
    assign led_color   = led_en ? cur_color : RED;
    assign input_ready = (state == WAIT_IN);
    assign game_over   = (state == LOSE);
    assign win         = (state == WIN);
    assign level       = len;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with MAX_LEN=3, ON_CYCLES=4, OFF_CYCLES=2.
module tb_simon_sequencer;

    localparam int MAX_LEN    = 3;
    localparam int ON_CYCLES  = 4;
    localparam int OFF_CYCLES = 2;
    localparam int LW         = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   random_num;
    logic          btn_valid;
    logic [1:0]    btn_color;
    logic          led_en;
    logic [1:0]    led_color;
    logic          input_ready;
    logic [LW-1:0] level;
    logic          game_over;
    logic          win;

    int errors = 0;
    int checks = 0;

    simon_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_CYCLES),
        .OFF_CYCLES (OFF_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .random_num  (random_num),
        .btn_valid   (btn_valid),
        .btn_color   (btn_color),
        .led_en      (led_en),
        .led_color   (led_color),
        .input_ready (input_ready),
        .level       (level),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic rdy,
                                 input logic [LW-1:0] lvl, input logic go, input logic wn);
        check({tag, ".led_en"}, 32'(led_en), 32'(en));
        check({tag, ".input_ready"}, 32'(input_ready), 32'(rdy));
        check({tag, ".level"}, 32'(level), 32'(lvl));
        check({tag, ".game_over"}, 32'(game_over), 32'(go));
        check({tag, ".win"}, 32'(win), 32'(wn));
    endtask

    // Pulse start with the given colour on random_num[1:0]; returns in the ADD cycle.
    task automatic pulse_start(input logic [1:0] rnd);
        random_num = ($urandom() & 32'hFFFF_FFFC) | {30'h0, rnd};
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one button press for a single edge.
    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        tick();
        btn_valid = 1'b0;
    endtask

    // Called in the first SHOW_ON cycle; checks the whole playback of n colours
    // and that input_ready rises right after the last dark gap.
    task automatic play(input string tag, input logic [5:0] cols, input int n,
                        input logic [LW-1:0] lvl, input bit inject_btn);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < ON_CYCLES; k++) begin
                check($sformatf("%s.on%0d_%0d.led_en", tag, i, k), 32'(led_en), 32'd1);
                check($sformatf("%s.on%0d_%0d.color", tag, i, k), 32'(led_color), 32'(cols[2*i +: 2]));
                check($sformatf("%s.on%0d_%0d.level", tag, i, k), 32'(level), 32'(lvl));
                if (inject_btn && i == 0 && k == 1) begin
                    btn_valid = 1'b1;
                    btn_color = ~cols[1:0];
                end
                tick();
                btn_valid = 1'b0;
            end
            for (int k = 0; k < OFF_CYCLES; k++) begin
                check($sformatf("%s.off%0d_%0d.led_en", tag, i, k), 32'(led_en), 32'd0);
                check($sformatf("%s.off%0d_%0d.ready", tag, i, k), 32'(input_ready), 32'd0);
                tick();
            end
        end
        check({tag, ".ready_after_play"}, 32'(input_ready), 32'd1);
        check({tag, ".led_after_play"}, 32'(led_en), 32'd0);
        check({tag, ".level_after_play"}, 32'(level), 32'(lvl));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        random_num = 32'h0;
        btn_valid  = 1'b0;
        btn_color  = 2'd0;

        // Power-on reset.
        tick();
        tick();
        check_outputs("por", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_outputs("idle", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Reset asserted mid-SHOW_ON clears outputs in the same cycle.
        pulse_start(2'd2);
        tick();
        check("rst_mid.led_before", 32'(led_en), 32'd1);
        check("rst_mid.level_before", 32'(level), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_outputs("rst_mid.same_cycle", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_outputs("rst_mid.after", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // btn_valid ignored in IDLE.
        press(2'd2);
        check_outputs("idle_btn", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Round 1: colour 2; a stray press during SHOW_ON must be ignored.
        pulse_start(2'd2);
        check_outputs("r1.add", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        play("r1", 6'b00_00_10, 1, 2'd1, 1'b1);

        // start ignored in WAIT_IN.
        random_num = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outputs("wait_start", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);

        // Correct press for round 1; random_num[1:0]=0 is sampled in ADD.
        press(2'd2);
        check_outputs("r1.ans_add", 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        play("r2", 6'b00_00_10, 2, 2'd2, 1'b0);

        // Round 2 answers; first press only advances idx.
        press(2'd2);
        check_outputs("r2.ans0", 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        random_num = 32'h0000_0003;
        press(2'd0);
        check_outputs("r2.ans_add", 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        play("r3", 6'b11_00_10, 3, 2'd3, 1'b0);

        // Round 3 answers; completing length MAX_LEN is a win.
        press(2'd2);
        check_outputs("r3.ans0", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        press(2'd0);
        check_outputs("r3.ans1", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        press(2'd3);
        check_outputs("r3.win", 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        press(2'd1);
        check_outputs("win.sticky", 1'b0, 1'b0, 2'd3, 1'b0, 1'b1);

        // Restart from WIN, then a wrong press.
        pulse_start(2'd2);
        check_outputs("g2.add", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        play("g2r1", 6'b00_00_10, 1, 2'd1, 1'b0);
        press(2'd1);
        check_outputs("lose", 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        press(2'd2);
        check_outputs("lose.ignore_btn", 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);

        // Restart from LOSE with colour 1.
        pulse_start(2'd1);
        check_outputs("g3.add", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        play("g3r1", 6'b00_00_01, 1, 2'd1, 1'b0);
        check("g3.game_over", 32'(game_over), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game-round controller for Sly-Man-Says. It samples the free-running LFSR's `random_num` to grow a colour sequence one step per round and plays the sequence on the LED driver. It then checks the player's button presses against the stored sequence and reports level, loss or win. It sits between the LFSR and the LED driver, button debouncer and score display, and is the only consumer of `random_num`.

## Interface
Parameters:
- `MAX_LEN`, 16: longest sequence; completing a round at this length is a win.
- `ON_CYCLES`, 25_000_000: clock cycles each colour is lit during playback; must be ≥1.
- `OFF_CYCLES`, 12_500_000: dark gap after each lit colour; must be ≥1.

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: single-cycle pulse; begins a new game.
- `random_num` in 32: LFSR output; only bits [1:0] are used.
- `btn_valid` in 1: single-cycle pulse; a debounced button press.
- `btn_color` in 2: colour of the press; valid when `btn_valid` is 1.
- `led_en` out 1: LED on during playback.
- `led_color` out 2: colour to light; meaningful only while `led_en` is 1.
- `input_ready` out 1: controller is waiting for player presses.
- `level` out $clog2(MAX_LEN+1): current sequence length.
- `game_over` out 1: sticky; the player pressed a wrong button.
- `win` out 1: sticky; the player completed a round of length MAX_LEN.

## Operation
- Colour encoding: 0 red, 1 green, 2 blue, 3 yellow.
- Storage: `seq[MAX_LEN]` × 2 bits, length counter `len`, index `idx`.
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN.

State behaviour and transitions:
- IDLE: all outputs 0. On `start`: `len`←0, clear flags, go to ADD.
- ADD (1 cycle): `seq[len]`←`random_num[1:0]`, `len`←`len+1`, `idx`←0, timer←0, go to SHOW_ON.
- SHOW_ON: `led_en`=1, `led_color`=`seq[idx]`. After ON_CYCLES cycles: timer←0, go to SHOW_OFF.
- SHOW_OFF: `led_en`=0. After OFF_CYCLES cycles:
  - if `idx==len-1`: `idx`←0, go to WAIT_IN;
  - else `idx`←`idx+1`, go to SHOW_ON.
- WAIT_IN: `input_ready`=1. On `btn_valid`:
  - `btn_color`≠`seq[idx]`: go to LOSE.
  - Match with `idx<len-1`: `idx`←`idx+1`.
  - Match with `idx==len-1` and `len<MAX_LEN`: go to ADD.
  - Match with `idx==len-1` and `len==MAX_LEN`: go to WIN.
- LOSE: `game_over`=1; `level` holds the last length.
- WIN: `win`=1; `level`=MAX_LEN.
- From LOSE or WIN, `start` restarts exactly as from IDLE.

Ignored inputs:
- `btn_valid` is ignored in every state except WAIT_IN.
- `start` is ignored in ADD, SHOW_ON, SHOW_OFF and WAIT_IN.

Other rules:
- `start` and `btn_valid` high in the same cycle: `start` takes priority in IDLE, LOSE and WIN; `btn_valid` takes priority in WAIT_IN.
- `seq` entries at index ≥`len` are don't-care and are never read.
- A new game overwrites entries in order, so `seq` needs no reset.

## Timing
- Reset values: state IDLE, `len`=0, `idx`=0, timer=0, and every output 0.
- `reset` asserted mid-game returns to IDLE immediately, with outputs 0 in the same cycle.
- `start` sampled high at edge N: ADD during cycle N+1, `led_en` first high in cycle N+2.
- `led_en` is high for exactly ON_CYCLES consecutive cycles per colour, then low for exactly OFF_CYCLES.
- `input_ready` rises in the cycle after the last OFF period ends.
- A press is evaluated at the edge where `btn_valid` is high. The response appears in the next cycle:
  - advanced `idx`;
  - or ADD, with `input_ready` low;
  - or `game_over` or `win` high.
- All outputs are registered or decoded from the state register only; no input-to-output combinational paths.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1). Timer counts from 0 and wraps to 0 on each phase change.

## Structure
- `simon_pkg` holds:
  - the state enum `simon_state_t`;
  - the colour typedef `color_t` (2 bits), with constants RED, GREEN, BLUE and YELLOW.
- Sub-module `phase_timer` holds the timer:
  - inputs: `load` and `limit`;
  - output: single-cycle `done`;
  - async reset on `reset`.
- The sequence store is a register array inside `simon_sequencer`.

## Test plan
Bench parameters: MAX_LEN=3, ON_CYCLES=4, OFF_CYCLES=2, `random_num` driven by the bench.

- **Reset:** assert `reset` mid-SHOW_ON → all outputs 0 in the same cycle; state IDLE after release.
- **First round:** `random_num[1:0]`=2, pulse `start` → `led_en` high for 4 cycles with `led_color`=2 starting 2 cycles after `start`, low for 2 cycles, then `input_ready`=1 and `level`=1.
- **Correct rounds:** sample colours 2, 0, 3 and answer each round correctly → round 2 plays 2 then 0, round 3 plays 2, 0, 3; after the final correct press `win`=1, `level`=3, `input_ready`=0.
- **Wrong press:** press colour 1 when `seq[0]`=2 → `game_over`=1 next cycle; `level` stays 1; later presses are ignored.
- **Ignored inputs:** pulse `btn_valid` during SHOW_ON and `start` during WAIT_IN → no change to state, `idx` or outputs.
- **Restart:** pulse `start` in LOSE with `random_num[1:0]`=1 → `game_over` clears, `level`=1, playback shows colour 1.
